// File: rtl/exec_pkg.sv
`default_nettype none
// exec_pkg: opcode encodings, control-signal bit positions and FSM state type
// shared by the execute stage and its iterative multiply/divide unit.
package exec_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_AND  = 6'd2;
  localparam logic [5:0] OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR  = 6'd4;
  localparam logic [5:0] OP_SLT  = 6'd5;
  localparam logic [5:0] OP_SLTU = 6'd6;
  localparam logic [5:0] OP_SLL  = 6'd7;
  localparam logic [5:0] OP_SRL  = 6'd8;
  localparam logic [5:0] OP_SRA  = 6'd9;
  localparam logic [5:0] OP_MUL  = 6'd10;
  localparam logic [5:0] OP_DIVU = 6'd11;
  localparam logic [5:0] OP_REMU = 6'd12;

  localparam int SIG_ALUSRC   = 7;
  localparam int SIG_MEMTOREG = 6;
  localparam int SIG_REGWRITE = 5;
  localparam int SIG_MEMREAD  = 4;
  localparam int SIG_MEMWRITE = 3;
  localparam int SIG_BRANCH   = 2;
  localparam int SIG_EQ       = 1;
  localparam int SIG_GOTO     = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider.
// done_o pulses in the cycle of the final step; result_o already includes that step.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [5:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt_q;
  logic            div_q, sel_rem_q;
  logic [XLEN-1:0] x_q, y_q, acc_q;
  logic [XLEN-1:0] x_d, y_d, acc_d;
  logic [XLEN:0]   rem_sh, diff;

  // MUL: acc += x when y[0]; x<<1, y>>1. DIV: x holds dividend/quotient, acc the remainder.
  always_comb begin
    rem_sh = {acc_q, x_q[XLEN-1]};
    diff   = rem_sh - {1'b0, y_q};
    x_d    = x_q;
    y_d    = y_q;
    acc_d  = acc_q;
    if (div_q) begin
      if (!diff[XLEN]) begin
        acc_d = diff[XLEN-1:0];
        x_d   = {x_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[XLEN-1:0];
        x_d   = {x_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_d = acc_q + (y_q[0] ? x_q : '0);
      x_d   = x_q << 1;
      y_d   = y_q >> 1;
    end
  end

  assign done_o   = (cnt_q == CW'(1));
  assign result_o = (div_q && !sel_rem_q) ? x_d : acc_d;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      cnt_q     <= '0;
      div_q     <= 1'b0;
      sel_rem_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
    end else if (start_i) begin
      cnt_q     <= CW'(XLEN);
      div_q     <= (op_i != OP_MUL);
      sel_rem_q <= (op_i == OP_REMU);
      x_q       <= a_i;
      y_q       <= b_i;
      acc_q     <= '0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/execute_stage_mc.sv
`default_nettype none
// execute_stage_mc: registered valid/ready execute stage with single-cycle ALU,
// branch/goto resolution and a stalling iterative MUL/DIVU/REMU path.
module execute_stage_mc
  import exec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PC_STEP   = 4,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_goto,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_offset,
  input  logic [4:0]      in_dest,
  input  logic [5:0]      in_op,
  input  logic [7:0]      in_signals,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_dest,
  output logic [7:0]      out_signals,
  output logic            out_jump,
  output logic [XLEN-1:0] out_jump_addr,
  output logic            busy
);

  localparam int              SHW  = $clog2(XLEN);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  state_t          state_q, state_d;
  logic            valid_q, valid_d, jump_q;
  logic [XLEN-1:0] result_q, jaddr_q;
  logic [4:0]      dest_q, pend_dest_q;
  logic [7:0]      sig_q, pend_sig_q;

  logic [XLEN-1:0] opb, alu_res, md_result, jaddr;
  logic [SHW-1:0]  shamt;
  logic            is_md, iter_op, accept, load_alu, start_md, md_done, md_load, jump;

  assign opb      = in_signals[SIG_ALUSRC] ? in_offset : in_b;
  assign shamt    = opb[SHW-1:0];
  assign is_md    = is_muldiv(in_op);
  assign iter_op  = is_md && MULDIV_EN;
  assign in_ready = (state_q == ST_IDLE) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign start_md = accept && iter_op;
  assign load_alu = accept && !iter_op;
  assign md_load  = md_done && (state_q == ST_ITER) && !flush;

  // Muldiv opcodes fall to the default arm: result 0 when no iterative unit exists.
  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = in_a + opb;
      OP_SUB:  alu_res = in_a - opb;
      OP_AND:  alu_res = in_a & opb;
      OP_OR:   alu_res = in_a | opb;
      OP_XOR:  alu_res = in_a ^ opb;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(opb)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, in_a < opb};
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(in_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  assign jump  = !is_md && (in_signals[SIG_GOTO] ||
                 (in_signals[SIG_BRANCH] &&
                  (in_signals[SIG_EQ] ? (alu_res == '0) : (alu_res != '0))));
  assign jaddr = in_signals[SIG_GOTO] ? in_goto : (in_pc + STEP + STEP * in_offset);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_md) state_d = ST_ITER;
      ST_ITER: if (flush || md_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    valid_d = valid_q && !out_ready;
    if (load_alu || md_load) valid_d = 1'b1;
    if (flush) valid_d = 1'b0;
  end

  generate
    if (MULDIV_EN) begin : g_muldiv
      muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk_i    (clock),
        .rst_i    (reset),
        .flush_i  (flush),
        .start_i  (start_md),
        .op_i     (in_op),
        .a_i      (in_a),
        .b_i      (opb),
        .done_o   (md_done),
        .result_o (md_result)
      );
    end else begin : g_no_muldiv
      assign md_done   = 1'b0;
      assign md_result = '0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      result_q    <= '0;
      dest_q      <= '0;
      sig_q       <= '0;
      jump_q      <= 1'b0;
      jaddr_q     <= '0;
      pend_dest_q <= '0;
      pend_sig_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (load_alu) begin
        result_q <= alu_res;
        dest_q   <= in_dest;
        sig_q    <= in_signals;
        jump_q   <= jump;
        jaddr_q  <= jaddr;
      end else if (md_load) begin
        result_q <= md_result;
        dest_q   <= pend_dest_q;
        sig_q    <= pend_sig_q;
        jump_q   <= 1'b0;
        jaddr_q  <= '0;
      end
      if (start_md) begin
        pend_dest_q <= in_dest;
        pend_sig_q  <= in_signals;
      end
    end
  end

  assign out_valid     = valid_q;
  assign out_result    = result_q;
  assign out_dest      = dest_q;
  assign out_signals   = sig_q;
  assign out_jump      = jump_q;
  assign out_jump_addr = jaddr_q;
  assign busy          = (state_q == ST_ITER);

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_mc.sv
`default_nettype none
// Bench for execute_stage_mc: vector table through a scoreboard, plus latency,
// backpressure, flush and reset sequences.
module tb_execute_stage_mc;
  import exec_pkg::*;

  localparam int XLEN = 32;

  logic            clock = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [XLEN-1:0] in_pc = '0, in_goto = '0, in_a = '0, in_b = '0, in_offset = '0;
  logic [4:0]      in_dest = '0;
  logic [5:0]      in_op = '0;
  logic [7:0]      in_signals = '0;
  logic            in_ready, out_valid, out_jump, busy;
  logic [XLEN-1:0] out_result, out_jump_addr;
  logic [4:0]      out_dest;
  logic [7:0]      out_signals;

  execute_stage_mc #(.XLEN(XLEN), .PC_STEP(4), .MULDIV_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_goto(in_goto), .in_a(in_a), .in_b(in_b), .in_offset(in_offset),
    .in_dest(in_dest), .in_op(in_op), .in_signals(in_signals), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_signals(out_signals), .out_jump(out_jump),
    .out_jump_addr(out_jump_addr), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, off, pc, go;
    logic [7:0]  sig;
    logic [31:0] res;
    logic        jump;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        jump;
    logic [31:0] addr;
    logic        chk_addr;
    logic [4:0]  dest;
    logic [7:0]  sig;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [7:0] sig, input logic [31:0] pc, input logic [31:0] off,
                              input logic [31:0] go, input logic [31:0] res, input logic jump);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sig = sig; v.pc = pc; v.off = off; v.go = go;
    v.res = res; v.jump = jump;
    return v;
  endfunction

  function automatic logic [31:0] model_addr(input vec_t v);
    return v.sig[SIG_GOTO] ? v.go : v.pc + 32'd4 + 32'd4 * v.off;
  endfunction

  task automatic push_exp(input vec_t v, input logic [4:0] dest);
    exp_t e;
    e.res = v.res; e.jump = v.jump; e.addr = model_addr(v);
    e.chk_addr = !is_muldiv(v.op); e.dest = dest; e.sig = v.sig;
    sb.push_back(e);
  endtask

  task automatic drive(input vec_t v, input logic [4:0] dest);
    in_op = v.op; in_a = v.a; in_b = v.b; in_offset = v.off; in_pc = v.pc;
    in_goto = v.go; in_signals = v.sig; in_dest = dest; in_valid = 1'b1;
  endtask

  // Returns at the falling edge before the accepting rising edge, in_valid still high.
  task automatic send(input vec_t v, input logic [4:0] dest);
    int  n;
    bit  ok;
    @(posedge clock); #1;
    drive(v, dest);
    n = 0; ok = 1'b0;
    while (!ok && n <= 100) begin
      @(negedge clock);
      if (in_ready) ok = 1'b1;
      else begin
        n++;
        @(posedge clock); #1;
      end
    end
    if (ok) push_exp(v, dest);
    else begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic idle();
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clock);
    while ((sb.size() != 0 || busy || out_valid) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got result 0x%0h with no pending expectation", out_result);
      end else begin
        e = sb.pop_front();
        chk("result", out_result, e.res);
        chk("jump", out_jump, e.jump);
        if (e.chk_addr) chk("jump_addr", out_jump_addr, e.addr);
        chk("dest", out_dest, e.dest);
        chk("signals", out_signals, e.sig);
      end
    end
  end

  initial begin
    vec_t tbl[$];
    vec_t v1, v2;
    int   busy_cnt, first_valid, ready_bad, valid_cnt;

    tbl.push_back(mk(OP_ADD,  32'd5,        32'd7,       8'h00, 32'h0,   32'h0,        32'h0,        32'd12,       1'b0));
    tbl.push_back(mk(OP_SUB,  32'd3,        32'd3,       8'h06, 32'h100, 32'd2,        32'h0,        32'd0,        1'b1));
    tbl.push_back(mk(OP_SUB,  32'd3,        32'd3,       8'h04, 32'h100, 32'd2,        32'h0,        32'd0,        1'b0));
    tbl.push_back(mk(OP_SUB,  32'd5,        32'd3,       8'h04, 32'h200, 32'hFFFFFFFF, 32'h0,        32'd2,        1'b1));
    tbl.push_back(mk(OP_AND,  32'hF0F0,     32'hFF00,    8'h20, 32'h0,   32'h0,        32'h0,        32'hF000,     1'b0));
    tbl.push_back(mk(OP_OR,   32'hF0F0,     32'hFF00,    8'h20, 32'h0,   32'h0,        32'h0,        32'hFFF0,     1'b0));
    tbl.push_back(mk(OP_XOR,  32'hF0F0,     32'hFF00,    8'h20, 32'h0,   32'h0,        32'h0,        32'h0FF0,     1'b0));
    tbl.push_back(mk(OP_SLT,  32'hFFFFFFFF, 32'd1,       8'h00, 32'h0,   32'h0,        32'h0,        32'd1,        1'b0));
    tbl.push_back(mk(OP_SLTU, 32'hFFFFFFFF, 32'd1,       8'h00, 32'h0,   32'h0,        32'h0,        32'd0,        1'b0));
    tbl.push_back(mk(OP_SLL,  32'd1,        32'd0,       8'h80, 32'h0,   32'd31,       32'h0,        32'h80000000, 1'b0));
    tbl.push_back(mk(OP_SLL,  32'd1,        32'd33,      8'h00, 32'h0,   32'h0,        32'h0,        32'd2,        1'b0));
    tbl.push_back(mk(OP_SRL,  32'h80000000, 32'd4,       8'h00, 32'h0,   32'h0,        32'h0,        32'h08000000, 1'b0));
    tbl.push_back(mk(OP_SRA,  32'h80000000, 32'd4,       8'h00, 32'h0,   32'h0,        32'h0,        32'hF8000000, 1'b0));
    tbl.push_back(mk(OP_ADD,  32'hFFFFFFFF, 32'd1,       8'h21, 32'h40,  32'd3,        32'hDEADBEE0, 32'd0,        1'b1));
    tbl.push_back(mk(OP_MUL,  32'hFFFF,     32'h10001,   8'h20, 32'h0,   32'h0,        32'h0,        32'hFFFFFFFF, 1'b0));
    tbl.push_back(mk(OP_MUL,  32'd7,        32'd6,       8'h01, 32'h0,   32'h0,        32'h40,       32'd42,       1'b0));
    tbl.push_back(mk(OP_DIVU, 32'd17,       32'd0,       8'h00, 32'h0,   32'h0,        32'h0,        32'hFFFFFFFF, 1'b0));
    tbl.push_back(mk(OP_REMU, 32'd17,       32'd0,       8'h00, 32'h0,   32'h0,        32'h0,        32'd17,       1'b0));
    tbl.push_back(mk(OP_DIVU, 32'd100,      32'd7,       8'h00, 32'h0,   32'h0,        32'h0,        32'd14,       1'b0));
    tbl.push_back(mk(OP_REMU, 32'd100,      32'd7,       8'h00, 32'h0,   32'h0,        32'h0,        32'd2,        1'b0));
    tbl.push_back(mk(OP_REMU, 32'hFFFFFFFF, 32'h10,      8'h00, 32'h0,   32'h0,        32'h0,        32'hF,        1'b0));
    tbl.push_back(mk(OP_DIVU, 32'h12345678, 32'd1,       8'h80, 32'h0,   32'h100,      32'h0,        32'h123456,   1'b0));

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_result", out_result, 0);
    chk("reset_jump", out_jump, 0);
    chk("reset_jump_addr", out_jump_addr, 0);
    chk("reset_dest_sig", {out_dest, out_signals}, 0);

    // Single-cycle latency
    send(tbl[0], 5'd1);
    idle();
    @(negedge clock);
    chk("add_latency_valid", out_valid, 1);
    wait_drain();

    for (int i = 0; i < tbl.size(); i++) send(tbl[i], 5'(i));
    idle();
    wait_drain();

    // MUL occupancy and latency
    send(tbl[14], 5'd9);
    idle();
    busy_cnt = 0; first_valid = 0; ready_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (busy && in_ready) ready_bad++;
      if (out_valid && first_valid == 0) first_valid = k;
    end
    chk("mul_busy_cycles", busy_cnt, 32);
    chk("mul_ready_while_busy", ready_bad, 0);
    chk("mul_valid_cycle", first_valid, 33);
    wait_drain();

    // Backpressure, then drain and accept in the same cycle
    v1 = mk(OP_ADD, 32'd1, 32'd2, 8'h20, 32'h0, 32'h0, 32'h0, 32'd3, 1'b0);
    v2 = mk(OP_ADD, 32'd10, 32'd20, 8'h20, 32'h0, 32'h0, 32'h0, 32'd30, 1'b0);
    out_ready = 1'b0;
    send(v1, 5'd3);
    @(posedge clock); #1;
    drive(v2, 5'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", out_result, 3);
      chk("bp_dest", out_dest, 3);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_ready", in_ready, 1);
    push_exp(v2, 5'd4);
    idle();
    @(negedge clock);
    chk("drain_accept_valid", out_valid, 1);
    chk("drain_accept_result", out_result, 30);
    wait_drain();

    // Flush drops a same-cycle accept
    @(posedge clock); #1;
    drive(v1, 5'd5);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("flush_drop_valid", out_valid, 0);

    // Flush and reset at ITER step 10 of a DIVU
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clock); #1;
      drive(tbl[18], 5'd7);
      @(negedge clock);
      chk("abort_accept_ready", in_ready, 1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clock);
      #1;
      if (pass == 0) flush = 1'b1; else reset = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0; reset = 1'b0;
      @(negedge clock);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_valid", out_valid, 0);
      if (pass == 1) chk("abort_reset_outputs", {out_result, out_jump_addr, out_jump, out_dest, out_signals}, 0);
      valid_cnt = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clock);
        if (out_valid) valid_cnt++;
      end
      chk("abort_no_result", valid_cnt, 0);
    end

    wait_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
